// File: rtl/sequence_error_checker_pkg.sv
// Shared defaults and capture-FSM encodings for the sequence error checker.
package sequence_error_checker_pkg;

    localparam int SEQ_LEN_DEF    = 6;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_W_DEF      = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACK      = 2'b01,
        WAIT_LOW = 2'b10
    } cap_state_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO of reference words; pointers carry an extra wrap bit for full/empty.
module seq_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]               wr_ptr, rd_ptr;
    logic [DEPTH-1:0][W-1:0]   mem;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Write and read may coincide even when full: head is read before the slot is overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/sequence_error_checker.sv
// Captures generator words into a FIFO, compares them with decoder output and
// accumulates saturating frame / bit-error / frame-error statistics.
module sequence_error_checker
    import sequence_error_checker_pkg::*;
#(
    parameter int SEQ_LEN    = SEQ_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEQ_LEN-1:0] random_sequence,
    input  logic               random_sequence_ready,
    output logic               random_sequence_ready_receive,
    input  logic [SEQ_LEN-1:0] decoded_sequence,
    input  logic               decoded_valid,
    output logic               decoded_ready,
    input  logic               counters_clear,
    output logic [CNT_W-1:0]   frame_count,
    output logic [CNT_W-1:0]   bit_error_count,
    output logic [CNT_W-1:0]   frame_error_count,
    output logic               last_frame_error,
    output logic               result_valid
);
    localparam int PC_W = $clog2(SEQ_LEN + 1);

    cap_state_t          state, state_nxt;
    logic                wr_en, pop, fifo_full, fifo_empty;
    logic [SEQ_LEN-1:0]  head, diff_q;
    logic [PC_W-1:0]     pc_q;
    logic [2:1]          vld_pipe;
    logic [CNT_W:0]      frame_sum, bit_sum, ferr_sum;
    logic                frame_err;

    function automatic logic [PC_W-1:0] popcount(input logic [SEQ_LEN-1:0] d);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < SEQ_LEN; i++)
            c = c + PC_W'(d[i]);
        return c;
    endfunction

    assign decoded_ready                 = !fifo_empty;
    assign pop                           = decoded_valid && !fifo_empty;
    assign random_sequence_ready_receive = (state == ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A full FIFO still accepts a word when the decoder pops in the same cycle.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (random_sequence_ready && (!fifo_full || pop)) begin
                    wr_en     = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:      state_nxt = WAIT_LOW;
            WAIT_LOW: if (!random_sequence_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    seq_fifo #(.W(SEQ_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (random_sequence),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Clear drops whatever is already in flight but keeps a word accepted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            diff_q   <= '0;
            pc_q     <= '0;
        end else begin
            vld_pipe[1] <= pop;
            vld_pipe[2] <= vld_pipe[1] && !counters_clear;
            if (pop) diff_q <= decoded_sequence ^ head;
            pc_q <= popcount(diff_q);
        end
    end

    assign frame_err = (pc_q != '0);
    assign frame_sum = {1'b0, frame_count} + (CNT_W+1)'(1);
    assign bit_sum   = {1'b0, bit_error_count} + (CNT_W+1)'(pc_q);
    assign ferr_sum  = {1'b0, frame_error_count} + (CNT_W+1)'(frame_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count       <= '0;
            bit_error_count   <= '0;
            frame_error_count <= '0;
            last_frame_error  <= 1'b0;
            result_valid      <= 1'b0;
        end else if (counters_clear) begin
            frame_count       <= '0;
            bit_error_count   <= '0;
            frame_error_count <= '0;
            last_frame_error  <= 1'b0;
            result_valid      <= 1'b0;
        end else begin
            result_valid <= vld_pipe[2];
            if (vld_pipe[2]) begin
                frame_count       <= frame_sum[CNT_W] ? '1 : frame_sum[CNT_W-1:0];
                bit_error_count   <= bit_sum[CNT_W]   ? '1 : bit_sum[CNT_W-1:0];
                frame_error_count <= ferr_sum[CNT_W]  ? '1 : ferr_sum[CNT_W-1:0];
                last_frame_error  <= frame_err;
            end
        end
    end

endmodule

// File: tb/tb_sequence_error_checker.sv
// Directed bench for sequence_error_checker with 4-bit counters so saturation is reachable.
module tb_sequence_error_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] random_sequence;
    logic       random_sequence_ready;
    logic       random_sequence_ready_receive;
    logic [5:0] decoded_sequence;
    logic       decoded_valid;
    logic       decoded_ready;
    logic       counters_clear;
    logic [3:0] frame_count, bit_error_count, frame_error_count;
    logic       last_frame_error, result_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int ack0;

    sequence_error_checker #(.SEQ_LEN(6), .FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .random_sequence               (random_sequence),
        .random_sequence_ready         (random_sequence_ready),
        .random_sequence_ready_receive (random_sequence_ready_receive),
        .decoded_sequence              (decoded_sequence),
        .decoded_valid                 (decoded_valid),
        .decoded_ready                 (decoded_ready),
        .counters_clear                (counters_clear),
        .frame_count                   (frame_count),
        .bit_error_count               (bit_error_count),
        .frame_error_count             (frame_error_count),
        .last_frame_error              (last_frame_error),
        .result_valid                  (result_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (random_sequence_ready_receive) ack_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int f, input int b, input int fe, input int lfe);
        chk({tag, "_frames"}, 32'(frame_count), f);
        chk({tag, "_biterr"}, 32'(bit_error_count), b);
        chk({tag, "_frmerr"}, 32'(frame_error_count), fe);
        chk({tag, "_last"},   32'(last_frame_error), lfe);
    endtask

    // Called at a negedge; returns at the negedge after the ack handshake completes.
    task automatic push(input logic [5:0] w, input int hold);
        int n;
        random_sequence       = w;
        random_sequence_ready = 1'b1;
        n = 0;
        while (!random_sequence_ready_receive && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", 32'(random_sequence_ready_receive), 1);
        repeat (hold) @(negedge clk);
        random_sequence_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One decoder transfer; returns at the negedge where the result should be visible.
    task automatic decode(input logic [5:0] w);
        chk("dec_ready", 32'(decoded_ready), 1);
        decoded_sequence = w;
        decoded_valid    = 1'b1;
        @(negedge clk);
        decoded_valid = 1'b0;
        chk("rv_lat0", 32'(result_valid), 0);
        @(negedge clk);
        chk("rv_lat1", 32'(result_valid), 0);
        @(negedge clk);
        chk("rv_lat2", 32'(result_valid), 1);
    endtask

    initial begin
        rst                   = 1'b1;
        random_sequence       = '0;
        random_sequence_ready = 1'b0;
        decoded_sequence      = '0;
        decoded_valid         = 1'b0;
        counters_clear        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_receive", 32'(random_sequence_ready_receive), 0);
        chk("rst_dready",  32'(decoded_ready), 0);
        chk("rst_rv",      32'(result_valid), 0);
        check_cnt("rst", 0, 0, 0, 0);

        // Asynchronous reset in the middle of an acknowledge
        rst = 1'b0;
        random_sequence       = 6'b110110;
        random_sequence_ready = 1'b1;
        @(negedge clk);
        chk("mid_ack", 32'(random_sequence_ready_receive), 1);
        #2 rst = 1'b1;
        random_sequence_ready = 1'b0;
        #1;
        chk("arst_receive", 32'(random_sequence_ready_receive), 0);
        chk("arst_dready",  32'(decoded_ready), 0);
        chk("arst_frames",  32'(frame_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single clean word
        ack0 = ack_cnt;
        push(6'b101101, 0);
        chk("single_acks", ack_cnt - ack0, 1);
        decode(6'b101101);
        check_cnt("single", 1, 0, 0, 0);
        @(negedge clk);
        chk("rv_pulse_end", 32'(result_valid), 0);
        chk("drained", 32'(decoded_ready), 0);

        // Three-bit error
        push(6'b000000, 0);
        decode(6'b100101);
        check_cnt("err3", 2, 3, 1, 1);

        // Ready held high after ack: exactly one capture
        ack0 = ack_cnt;
        push(6'b010101, 3);
        chk("hold_acks", ack_cnt - ack0, 1);
        decode(6'b010101);
        check_cnt("hold", 3, 3, 1, 0);

        // Backpressure: fifth word waits for a pop
        ack0 = ack_cnt;
        push(6'b000001, 0);
        push(6'b000011, 0);
        push(6'b111000, 0);
        push(6'b101010, 0);
        chk("bp_four_acks", ack_cnt - ack0, 4);
        random_sequence       = 6'b110011;
        random_sequence_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_stalled", ack_cnt - ack0, 4);
        chk("bp_no_recv", 32'(random_sequence_ready_receive), 0);
        decode(6'b000001);
        chk("bp_fifth_ack", ack_cnt - ack0, 5);
        check_cnt("bp_w1", 4, 3, 1, 0);
        random_sequence_ready = 1'b0;
        repeat (2) @(negedge clk);
        decode(6'b000000);
        check_cnt("bp_w2", 5, 5, 2, 1);
        decode(6'b111000);
        check_cnt("bp_w3", 6, 5, 2, 0);
        decode(6'b101011);
        check_cnt("bp_w4", 7, 6, 3, 1);
        decode(6'b110011);
        check_cnt("bp_w5", 8, 6, 3, 0);
        chk("bp_drained", 32'(decoded_ready), 0);

        // Saturation at 15
        for (int i = 0; i < 20; i++) begin
            push(6'b000000, 0);
            decode(6'b111111);
            if (i == 1) chk("sat_bits_early", 32'(bit_error_count), 15);
        end
        check_cnt("sat", 15, 15, 15, 1);

        // Clear coincident with an S2 update, plus a word accepted in the clear cycle
        push(6'b000000, 0);
        push(6'b000000, 0);
        decoded_sequence = 6'b000111;
        decoded_valid    = 1'b1;
        @(negedge clk);
        decoded_valid = 1'b0;
        @(negedge clk);
        decoded_sequence = 6'b000001;
        decoded_valid    = 1'b1;
        counters_clear   = 1'b1;
        @(negedge clk);
        decoded_valid  = 1'b0;
        counters_clear = 1'b0;
        chk("clr_rv", 32'(result_valid), 0);
        check_cnt("clr", 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_rv_next", 32'(result_valid), 0);
        @(negedge clk);
        chk("clr_word_rv", 32'(result_valid), 1);
        check_cnt("clr_word", 1, 1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
